// File: rtl/div8by4u_seq_if.sv
// Operand/result handshake bundle for the sequential unsigned divider.
// The master offers operands and consumes results; the slave is the divider.
interface div8by4u_seq_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend_i;
  logic [VW-1:0] divisor_i;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quot_o;
  logic [VW-1:0] rem_o;
  logic          dbz_o;
  logic          err_o;

  modport master (
    output in_valid, dividend_i, divisor_i, out_ready,
    input  in_ready, out_valid, quot_o, rem_o, dbz_o, err_o
  );

  modport slave (
    input  in_valid, dividend_i, divisor_i, out_ready,
    output in_ready, out_valid, quot_o, rem_o, dbz_o, err_o
  );
endinterface

// File: rtl/div8by4u_seq.sv
// Restoring unsigned divider, one quotient bit per cycle, with an optional
// q*d + r residue check before the result is presented.
module div8by4u_seq #(
  parameter int unsigned DW       = 8,
  parameter int unsigned VW       = 4,
  parameter bit          CHECK_EN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  div8by4u_seq_if.slave   bus
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  state_e r_state, w_state_nxt;

  logic [DW-1:0] r_dvd;       // original dividend, kept for the residue check
  logic [DW-1:0] r_dvd_sh;    // dividend shifted out MSB first
  logic [VW-1:0] r_dvs;
  logic [VW:0]   r_p;
  logic [DW-1:0] r_quot;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_quot_out;
  logic [VW-1:0] r_rem_out;
  logic          r_dbz;
  logic          r_err;

  logic [VW:0]      w_p_shift;
  logic             w_ge;
  logic [VW:0]      w_p_nxt;
  logic [DW-1:0]    w_q_nxt;
  logic             w_last;
  logic [DW+VW-1:0] w_sum;
  logic             w_check_fail;

  assign w_p_shift    = {r_p[VW-1:0], r_dvd_sh[DW-1]};
  assign w_ge         = (w_p_shift >= {1'b0, r_dvs});
  assign w_p_nxt      = w_ge ? (w_p_shift - {1'b0, r_dvs}) : w_p_shift;
  assign w_q_nxt      = {r_quot[DW-2:0], w_ge};
  assign w_last       = (r_cnt == '0);
  assign w_sum        = ({{VW{1'b0}}, r_quot} * {{DW{1'b0}}, r_dvs})
                        + {{(DW-1){1'b0}}, r_p};
  assign w_check_fail = (w_sum != {{VW{1'b0}}, r_dvd});

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.divisor_i == '0) w_state_nxt = StDone;
          else                     w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (w_last) begin
          if (CHECK_EN) w_state_nxt = StCheck;
          else          w_state_nxt = StDone;
        end
      end
      StCheck: w_state_nxt = StDone;
      StDone:  if (bus.out_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_dvd      <= '0;
      r_dvd_sh   <= '0;
      r_dvs      <= '0;
      r_p        <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
      r_quot_out <= '0;
      r_rem_out  <= '0;
      r_dbz      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_dvd    <= bus.dividend_i;
            r_dvd_sh <= bus.dividend_i;
            r_dvs    <= bus.divisor_i;
            r_p      <= '0;
            r_quot   <= '0;
            r_cnt    <= CW'(DW - 1);
            r_err    <= 1'b0;
            if (bus.divisor_i == '0) begin
              r_quot_out <= '1;
              r_rem_out  <= '0;
              r_dbz      <= 1'b1;
            end else begin
              r_dbz <= 1'b0;
            end
          end
        end
        StRun: begin
          r_p      <= w_p_nxt;
          r_quot   <= w_q_nxt;
          r_dvd_sh <= {r_dvd_sh[DW-2:0], 1'b0};
          r_cnt    <= r_cnt - CW'(1);
          // Without the check stage the result goes straight to DONE from here.
          if (w_last && !CHECK_EN) begin
            r_quot_out <= w_q_nxt;
            r_rem_out  <= w_p_nxt[VW-1:0];
          end
        end
        StCheck: begin
          r_err      <= w_check_fail;
          r_quot_out <= r_quot;
          r_rem_out  <= r_p[VW-1:0];
        end
        StDone:  ;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.quot_o    = r_quot_out;
  assign bus.rem_o     = r_rem_out;
  assign bus.dbz_o     = r_dbz;
  assign bus.err_o     = r_err;

endmodule

// File: tb/tb_div8by4u_seq.sv
// Directed-vector bench for div8by4u_seq: table of hand-computed results,
// stall/reset corner sequences and an exhaustive dividend x nonzero-divisor sweep.
module tb_div8by4u_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div8by4u_seq_if #(.DW(8), .VW(4)) bus ();

  div8by4u_seq #(.DW(8), .VW(4), .CHECK_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the DONE-exit edge.
  task automatic run_op(input logic [7:0] dvd, input logic [3:0] dvs,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic dbz, output logic err, output int lat);
    bus.dividend_i = dvd;
    bus.divisor_i  = dvs;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q   = bus.quot_o;
    r   = bus.rem_o;
    dbz = bus.dbz_o;
    err = bus.err_o;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz, err;
    int         lat;
    int         seen;

    vecs[0]  = '{8'h64, 4'h7, 8'h0E, 4'h2, 1'b0, 10};
    vecs[1]  = '{8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 10};
    vecs[2]  = '{8'hE1, 4'hF, 8'h0F, 4'h0, 1'b0, 10};
    vecs[3]  = '{8'h2A, 4'h0, 8'hFF, 4'h0, 1'b1, 1};
    vecs[4]  = '{8'h00, 4'h5, 8'h00, 4'h0, 1'b0, 10};
    vecs[5]  = '{8'h07, 4'h8, 8'h00, 4'h7, 1'b0, 10};
    vecs[6]  = '{8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 10};
    vecs[7]  = '{8'hC8, 4'h3, 8'h42, 4'h2, 1'b0, 10};
    vecs[8]  = '{8'h09, 4'h9, 8'h01, 4'h0, 1'b0, 10};
    vecs[9]  = '{8'hFE, 4'hF, 8'h10, 4'hE, 1'b0, 10};
    vecs[10] = '{8'h80, 4'hF, 8'h08, 4'h8, 1'b0, 10};
    vecs[11] = '{8'hFF, 4'h2, 8'h7F, 4'h1, 1'b0, 10};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_quot", bus.quot_o, 0);
    chk("reset_rem", bus.rem_o, 0);
    chk("reset_dbz", bus.dbz_o, 0);
    chk("reset_err", bus.err_o, 0);

    // Issued back-to-back: each op starts in the first IDLE cycle after the previous.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, q, r, dbz, err, lat);
      chk($sformatf("vec%0d_quot", i), q, vecs[i].q);
      chk($sformatf("vec%0d_rem", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
      chk($sformatf("vec%0d_err", i), err, 0);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_idle_ready", i), bus.in_ready, 1);
    end

    // dbz must clear on the next accept while quot_o holds its old value.
    run_op(8'h2A, 4'h0, q, r, dbz, err, lat);
    bus.dividend_i = 8'h64;
    bus.divisor_i  = 4'h7;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    chk("accept_clears_dbz", bus.dbz_o, 0);
    chk("busy_in_ready", bus.in_ready, 0);
    chk("quot_holds_in_run", bus.quot_o, 8'hFF);
    // in_valid stays high with other operands through the busy and stall period.
    bus.dividend_i = 8'h10;
    bus.divisor_i  = 4'h1;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_latency", lat, 10);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_quot", c), bus.quot_o, 8'h0E);
      chk($sformatf("stall%0d_rem", c), bus.rem_o, 4'h2);
      chk($sformatf("stall%0d_valid_ready", c), {bus.out_valid, bus.in_ready}, 2'b10);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);

    // Reset during the 4th RUN cycle discards the operation.
    bus.dividend_i = 8'hC8;
    bus.divisor_i  = 4'h3;
    bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_busy", bus.in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_rst_in_ready", bus.in_ready, 1);
    chk("midrun_rst_out_valid", bus.out_valid, 0);
    chk("midrun_rst_quot", bus.quot_o, 0);
    chk("midrun_rst_rem", bus.rem_o, 0);
    chk("midrun_rst_flags", {bus.dbz_o, bus.err_o}, 0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("midrun_rst_no_result", seen, 0);

    for (int a = 0; a < 256; a++) begin
      for (int d = 1; d < 16; d++) begin
        logic [7:0] eq;
        logic [3:0] er;
        eq = 8'(a / d);
        er = 4'(a % d);
        run_op(8'(a), 4'(d), q, r, dbz, err, lat);
        chk($sformatf("sweep_%0d_div_%0d", a, d),
            {10'd0, q, r, dbz, err, lat[7:0]}, {10'd0, eq, er, 1'b0, 1'b0, 8'd10});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
